xmem_rd_stream: RTL and testbench

//  Source end of the Versat data bus: sequences reads from one memory port and

---
 rtl/xmem_rd_stream_pkg.sv | 19 +
 rtl/xmem_rd_stream_if.sv | 21 ++
 rtl/xmem_rd_stream_xagu_loop.sv | 52 +++++
 rtl/xmem_rd_stream.sv | 105 ++++++++++
 tb/tb_xmem_rd_stream.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/xmem_rd_stream_pkg.sv
// Shared definitions for the Versat memory read stream source: conf field
// widths, packed configuration size, FSM encodings and bus slot index.
package xmem_rd_stream_pkg;

    localparam int XRD_DATA_W   = 32;
    localparam int XRD_ADDR_W   = 10;
    localparam int XRD_PERIOD_W = 10;

    // start, incr, shift are address-wide; iter, per, duty, delay are period-wide
    localparam int RD_CONF_BITS = 3 * XRD_ADDR_W + 4 * XRD_PERIOD_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Position of this source's word among the flow_out slots of the data bus
    localparam int RD_SLOT = 0;

endpackage

// File: rtl/xmem_rd_stream_if.sv
// Memory read port plus the data bus slot driven by the read stream source.
interface xmem_rd_stream_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] flow_out;
    logic              flow_out_valid;

    modport master (
        output mem_en, mem_addr, flow_out, flow_out_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_addr, flow_out, flow_out_valid,
        output mem_rdata
    );
endinterface

// File: rtl/xmem_rd_stream_xagu_loop.sv
// Two-level (iterations x period) address generator with duty gating;
// addresses wrap modulo 2^ADDR_W.
module xagu_loop #(
    parameter int ADDR_W   = 10,
    parameter int PERIOD_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [PERIOD_W-1:0] iter,
    input  logic [PERIOD_W-1:0] per,
    input  logic [PERIOD_W-1:0] duty,
    input  logic [ADDR_W-1:0]   incr,
    input  logic [ADDR_W-1:0]   shift,
    output logic                en,
    output logic [ADDR_W-1:0]   addr,
    output logic                last
);
    localparam logic [PERIOD_W-1:0] ONE_P = 1;

    logic [PERIOD_W-1:0] per_cnt, iter_cnt, duty_eff;
    logic                empty, per_last;

    assign duty_eff = (duty > per) ? per : duty;
    // An empty loop still occupies one RUN cycle so the FSM has a uniform exit
    assign empty    = (iter == '0) || (per == '0);
    assign per_last = (per_cnt == per - ONE_P);
    assign en       = step && !empty && (per_cnt < duty_eff);
    assign last     = empty || (per_last && (iter_cnt == iter - ONE_P));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt  <= '0;
            iter_cnt <= '0;
            addr     <= '0;
        end else if (load) begin
            per_cnt  <= '0;
            iter_cnt <= '0;
            addr     <= load_addr;
        end else if (step && !empty) begin
            if (per_last) begin
                per_cnt  <= '0;
                iter_cnt <= iter_cnt + ONE_P;
            end else begin
                per_cnt  <= per_cnt + ONE_P;
            end
            addr <= addr + (en ? incr : '0) + (per_last ? shift : '0);
        end
    end
endmodule

// File: rtl/xmem_rd_stream.sv
// Versat read stream source: run-triggered delay/run FSM around xagu_loop,
// with a one-stage landing register that places read words on flow_out.
module xmem_rd_stream
    import xmem_rd_stream_pkg::*;
#(
    parameter int DATA_W   = XRD_DATA_W,
    parameter int ADDR_W   = XRD_ADDR_W,
    parameter int PERIOD_W = XRD_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                done,
    input  logic [ADDR_W-1:0]   conf_start,
    input  logic [PERIOD_W-1:0] conf_iter,
    input  logic [PERIOD_W-1:0] conf_per,
    input  logic [PERIOD_W-1:0] conf_duty,
    input  logic [ADDR_W-1:0]   conf_incr,
    input  logic [ADDR_W-1:0]   conf_shift,
    input  logic [PERIOD_W-1:0] conf_delay,
    xmem_rd_stream_if.master    bus
);
    localparam logic [PERIOD_W-1:0] ONE_P = 1;

    logic [1:0]          state;
    logic [PERIOD_W-1:0] dly_cnt;
    logic [PERIOD_W-1:0] iter_q, per_q, duty_q, delay_q;
    logic [ADDR_W-1:0]   incr_q, shift_q;
    logic                agu_en, agu_last;
    logic [ADDR_W-1:0]   agu_addr;
    logic                rd_vld, rd_cur;
    logic [DATA_W-1:0]   flow_q;
    logic                flow_vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
            iter_q  <= '0;
            per_q   <= '0;
            duty_q  <= '0;
            delay_q <= '0;
            incr_q  <= '0;
            shift_q <= '0;
        end else if (run) begin
            iter_q  <= conf_iter;
            per_q   <= conf_per;
            duty_q  <= conf_duty;
            delay_q <= conf_delay;
            incr_q  <= conf_incr;
            shift_q <= conf_shift;
            dly_cnt <= '0;
            state   <= (conf_delay == '0) ? ST_RUN : ST_DELAY;
        end else begin
            case (state)
                ST_DELAY: begin
                    if (dly_cnt == delay_q - ONE_P) state <= ST_RUN;
                    else                            dly_cnt <= dly_cnt + ONE_P;
                end
                ST_RUN:  if (agu_last) state <= ST_IDLE;
                ST_IDLE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    xagu_loop #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) u_agu (
        .clk       (clk),
        .rst       (rst),
        .load      (run),
        .step      (state == ST_RUN),
        .load_addr (conf_start),
        .iter      (iter_q),
        .per       (per_q),
        .duty      (duty_q),
        .incr      (incr_q),
        .shift     (shift_q),
        .en        (agu_en),
        .addr      (agu_addr),
        .last      (agu_last)
    );

    // A read issued alongside a restart still lands, but does not count as
    // belonging to the new sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld     <= 1'b0;
            rd_cur     <= 1'b0;
            flow_q     <= '0;
            flow_vld_q <= 1'b0;
        end else begin
            rd_vld <= agu_en;
            rd_cur <= agu_en && !run;
            if (rd_vld) flow_q <= bus.mem_rdata;
            if (run)                   flow_vld_q <= 1'b0;
            else if (rd_vld && rd_cur) flow_vld_q <= 1'b1;
        end
    end

    assign done               = (state == ST_IDLE);
    assign bus.mem_en         = agu_en;
    assign bus.mem_addr       = agu_addr;
    assign bus.flow_out       = flow_q;
    assign bus.flow_out_valid = flow_vld_q;
endmodule

// File: tb/tb_xmem_rd_stream.sv
// Scoreboard bench for xmem_rd_stream: a loop model predicts read cycles,
// addresses and landed words; a negedge monitor compares them.
module tb_xmem_rd_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       done;
    logic [9:0] conf_start, conf_incr, conf_shift;
    logic [9:0] conf_iter, conf_per, conf_duty, conf_delay;

    xmem_rd_stream_if #(.DATA_W(32), .ADDR_W(10)) bus ();

    xmem_rd_stream #(.DATA_W(32), .ADDR_W(10), .PERIOD_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .done       (done),
        .conf_start (conf_start),
        .conf_iter  (conf_iter),
        .conf_per   (conf_per),
        .conf_duty  (conf_duty),
        .conf_incr  (conf_incr),
        .conf_shift (conf_shift),
        .conf_delay (conf_delay),
        .bus        (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t        rq[$];
    exp_t        fq[$];
    logic [31:0] mem [1024];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk)
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            chk("mem_en", 32'(bus.mem_en), 32'd1);
            chk("mem_addr", 32'(bus.mem_addr), rq[0].val);
            void'(rq.pop_front());
        end else begin
            chk("mem_en_idle", 32'(bus.mem_en), 32'd0);
        end
        if (fq.size() > 0 && fq[0].cyc == cyc) begin
            chk("flow_out", bus.flow_out, fq[0].val);
            chk("flow_valid", 32'(bus.flow_out_valid), 32'd1);
            void'(fq.pop_front());
        end
    end

    // Drive one run pulse and push the predicted read/landing schedule.
    task automatic launch(input int start, input int iter, input int per, input int duty,
                          input int incr, input int shift, input int delay);
        logic [9:0] a;
        int b, k, dl;
        @(negedge clk);
        conf_start = 10'(start);
        conf_iter  = 10'(iter);
        conf_per   = 10'(per);
        conf_duty  = 10'(duty);
        conf_incr  = 10'(incr);
        conf_shift = 10'(shift);
        conf_delay = 10'(delay);
        run = 1'b1;
        b  = cyc + 1 + delay;
        a  = conf_start;
        k  = 0;
        dl = (duty > per) ? per : duty;
        for (int it = 0; it < iter; it++)
            for (int p = 0; p < per; p++) begin
                if (p < dl) begin
                    rq.push_back('{b + k, 32'(a)});
                    fq.push_back('{b + k + 2, mem[a]});
                    a = a + conf_incr;
                end
                if (p == per - 1) a = a + conf_shift;
                k++;
            end
        exp_done = b + ((iter * per == 0) ? 1 : iter * per);
        @(negedge clk);
        run = 1'b0;
        chk("done_after_run", 32'(done), 32'd0);
        chk("valid_cleared", 32'(bus.flow_out_valid), 32'd0);
    endtask

    task automatic finish_seq(input string tag);
        int k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_cyc"}, 32'(cyc), 32'(exp_done));
        repeat (3) @(negedge clk);
        chk({tag, "_rd_left"}, 32'(rq.size()), 32'd0);
        chk({tag, "_flow_left"}, 32'(fq.size()), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 100);
        rst = 1'b0;
        run = 1'b0;
        {conf_start, conf_iter, conf_per, conf_duty} = '0;
        {conf_incr, conf_shift, conf_delay} = '0;
        #1;
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_en", 32'(bus.mem_en), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_flow", bus.flow_out, 32'd0);
        chk("rst_valid", 32'(bus.flow_out_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        launch(0, 1, 4, 4, 1, 0, 0);     finish_seq("linear");
        launch(8, 3, 2, 2, 1, 2, 0);     finish_seq("twod");
        launch(20, 2, 5, 2, 1, 0, 3);    finish_seq("duty_delay");
        launch(1022, 1, 4, 4, 1, 0, 0);  finish_seq("wrap_up");
        launch(1, 1, 4, 4, -1, 0, 0);    finish_seq("wrap_down");
        launch(50, 0, 4, 4, 1, 0, 0);    finish_seq("iter0");
        launch(60, 2, 3, 7, 1, 5, 1);    finish_seq("duty_clamp");
        launch(70, 2, 0, 2, 1, 0, 2);    finish_seq("per0");

        // Reset one cycle after the second read of a longer sequence
        launch(0, 1, 8, 8, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_done", 32'(done), 32'd1);
        chk("mid_rst_en", 32'(bus.mem_en), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst_flow", bus.flow_out, 32'd0);
        chk("mid_rst_valid", 32'(bus.flow_out_valid), 32'd0);
        rq.delete();
        fq.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        launch(5, 1, 4, 4, 1, 0, 0);     finish_seq("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
